// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: opcodes, FSM states, field positions.
// Optional feature macro: WB_BYPASS_EN (same-cycle writeback-to-read bypass).
package decode_pkg;

    localparam int unsigned NumRegs = 16;

    // Instruction field bit positions
    localparam int unsigned OpMsb  = 15;
    localparam int unsigned OpLsb  = 12;
    localparam int unsigned RdMsb  = 11;
    localparam int unsigned RdLsb  = 8;
    localparam int unsigned RsMsb  = 7;
    localparam int unsigned RsLsb  = 4;
    localparam int unsigned RtMsb  = 3;
    localparam int unsigned RtLsb  = 0;
    localparam int unsigned ImmMsb = 7;
    localparam int unsigned ImmLsb = 0;

    // Opcodes with special handling
    localparam logic [3:0] OpLui   = 4'hB;
    localparam logic [3:0] OpLoad  = 4'hC;
    localparam logic [3:0] OpStore = 4'hD;
    localparam logic [3:0] OpBr    = 4'hE;
    localparam logic [3:0] OpNop   = 4'hF;

    typedef enum logic [1:0] {
        StRun   = 2'd0,
        StStall = 2'd1,
        StFlush = 2'd2
    } state_e;

    // LUI places imm8 in the upper byte; everything else sign-extends it
    function automatic logic [15:0] imm_ext(input logic [15:0] ins);
        if (ins[OpMsb:OpLsb] == OpLui) begin
            return {ins[ImmMsb:ImmLsb], 8'h00};
        end
        return {{8{ins[ImmMsb]}}, ins[ImmMsb:ImmLsb]};
    endfunction

    // Every opcode up to and including LOAD produces a register result
    function automatic logic writes_reg(input logic [3:0] op);
        return (op <= OpLoad);
    endfunction

endpackage

// File: rtl/reg_file.sv
// 16x16 register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero.
module reg_file
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  raddr_a,
    output logic [15:0] rdata_a,
    input  logic [3:0]  raddr_b,
    output logic [15:0] rdata_b,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata
);

    logic [15:0] mem [NumRegs];

    // Storage: cleared on reset, writes to r0 dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumRegs; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != 4'd0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 4'd0) ? 16'h0000 : mem[raddr_a];
    assign rdata_b = (raddr_b == 4'd0) ? 16'h0000 : mem[raddr_b];

endmodule

// File: rtl/decode_stage.sv
// Pipeline decode stage: register read, immediate formation, load-use and
// writeback hazard stalls, branch flush, registered ID/EX outputs.
// Define WB_BYPASS_EN to forward same-cycle writeback data instead of stalling.
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] pc,
    input  logic [15:0] inst,
    input  logic        inst_valid,
    input  logic        branch_to_new,
    input  logic        wb_en,
    input  logic [3:0]  wb_addr,
    input  logic [15:0] wb_data,
    output logic        fetch_stall,
    output logic        ex_valid,
    output logic [15:0] ex_pc,
    output logic [3:0]  ex_op,
    output logic [3:0]  ex_rd,
    output logic [15:0] ex_a,
    output logic [15:0] ex_b,
    output logic [15:0] ex_imm,
    output logic        ex_wb_en
);

    state_e      state_q, state_d;
    logic [15:0] hold_inst_q, hold_pc_q;
    logic        accept, hold_load;

    logic [15:0] cur_inst, cur_pc;
    logic [3:0]  rs, rt;
    logic [15:0] rdata_a, rdata_b, opnd_a, opnd_b;
    logic        wb_hit_a, wb_hit_b, wb_conflict, load_use;

    // In STALL the latched instruction is the one being decoded
    assign cur_inst = (state_q == StStall) ? hold_inst_q : inst;
    assign cur_pc   = (state_q == StStall) ? hold_pc_q : pc;
    assign rs       = cur_inst[RsMsb:RsLsb];
    assign rt       = cur_inst[RtMsb:RtLsb];

    reg_file u_reg_file (
        .clk     (clk),
        .rst     (rst),
        .raddr_a (rs),
        .rdata_a (rdata_a),
        .raddr_b (rt),
        .rdata_b (rdata_b),
        .we      (wb_en),
        .waddr   (wb_addr),
        .wdata   (wb_data)
    );

    assign wb_hit_a = wb_en && (wb_addr == rs) && (rs != 4'd0);
    assign wb_hit_b = wb_en && (wb_addr == rt) && (rt != 4'd0);

`ifdef WB_BYPASS_EN
    assign opnd_a      = wb_hit_a ? wb_data : rdata_a;
    assign opnd_b      = wb_hit_b ? wb_data : rdata_b;
    assign wb_conflict = 1'b0;
`else
    assign opnd_a      = rdata_a;
    assign opnd_b      = rdata_b;
    assign wb_conflict = wb_hit_a || wb_hit_b;
`endif

    assign load_use = ex_valid && (ex_op == OpLoad) && (ex_rd != 4'd0) &&
                      ((ex_rd == rs) || (ex_rd == rt));

    // Next-state, accept and fetch-hold decisions; redirect overrides everything
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        hold_load   = 1'b0;
        fetch_stall = 1'b0;
        if (branch_to_new) begin
            state_d = StFlush;
        end else begin
            unique case (state_q)
                StFlush: state_d = StRun;
                StRun: begin
                    if (inst_valid) begin
                        if (load_use || wb_conflict) begin
                            state_d   = StStall;
                            hold_load = 1'b1;
                        end else begin
                            accept = 1'b1;
                        end
                    end
                end
                StStall: begin
                    fetch_stall = 1'b1;
                    // A fresh writeback clash keeps us here until the file is current
                    if (!wb_conflict) begin
                        accept  = 1'b1;
                        state_d = StRun;
                    end
                end
                default: state_d = StFlush;
            endcase
        end
    end

    // FSM state and the instruction held across a stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFlush;
            hold_inst_q <= '0;
            hold_pc_q   <= '0;
        end else begin
            state_q <= state_d;
            if (hold_load) begin
                hold_inst_q <= inst;
                hold_pc_q   <= pc;
            end
        end
    end

    // ID/EX register; bubbles clear only the valid and writeback flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid <= 1'b0;
            ex_pc    <= '0;
            ex_op    <= '0;
            ex_rd    <= '0;
            ex_a     <= '0;
            ex_b     <= '0;
            ex_imm   <= '0;
            ex_wb_en <= 1'b0;
        end else if (accept) begin
            ex_valid <= 1'b1;
            ex_pc    <= cur_pc;
            ex_op    <= cur_inst[OpMsb:OpLsb];
            ex_rd    <= cur_inst[RdMsb:RdLsb];
            ex_a     <= opnd_a;
            ex_b     <= opnd_b;
            ex_imm   <= imm_ext(cur_inst);
            ex_wb_en <= writes_reg(cur_inst[OpMsb:OpLsb]);
        end else begin
            ex_valid <= 1'b0;
            ex_wb_en <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations followed by randomized traffic checked against a behavioural model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] pc, inst, wb_data;
    logic        inst_valid, branch_to_new, wb_en;
    logic [3:0]  wb_addr;
    logic        fetch_stall, ex_valid, ex_wb_en;
    logic [15:0] ex_pc, ex_a, ex_b, ex_imm;
    logic [3:0]  ex_op, ex_rd;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .pc            (pc),
        .inst          (inst),
        .inst_valid    (inst_valid),
        .branch_to_new (branch_to_new),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .fetch_stall   (fetch_stall),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_op         (ex_op),
        .ex_rd         (ex_rd),
        .ex_a          (ex_a),
        .ex_b          (ex_b),
        .ex_imm        (ex_imm),
        .ex_wb_en      (ex_wb_en)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int ModeRun = 0, ModeStall = 1, ModeFlush = 2;

    int          m_mode, n_mode;
    logic [15:0] m_regs [16];
    logic [15:0] held_inst, held_pc;
    bit          m_fs;
    bit          exp_valid, exp_wben, n_valid, n_wben;
    logic [15:0] exp_pc, exp_a, exp_b, exp_imm, n_pc, n_a, n_b, n_imm;
    logic [3:0]  exp_op, exp_rd, n_op, n_rd;

    task automatic model_reset();
        m_mode = ModeFlush;
        for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
        exp_valid = 0; exp_wben = 0; exp_pc = 0; exp_op = 0; exp_rd = 0;
        exp_a = 0; exp_b = 0; exp_imm = 0; m_fs = 0;
    endtask

    function automatic bit uses_pending_load(input logic [15:0] ins);
        logic [3:0] s, t;
        s = ins[7:4];
        t = ins[3:0];
        return exp_valid && exp_op == 4'hC && exp_rd != 0 && (exp_rd == s || exp_rd == t);
    endfunction

    function automatic bit wb_clash(input logic [15:0] ins, input bit we, input logic [3:0] wa);
`ifdef WB_BYPASS_EN
        return 1'b0;
`else
        logic [3:0] s, t;
        s = ins[7:4];
        t = ins[3:0];
        return we && wa != 0 && (wa == s || wa == t);
`endif
    endfunction

    function automatic logic [15:0] read_reg(input logic [3:0] r, input bit we,
                                             input logic [3:0] wa, input logic [15:0] wd);
        if (r == 0) return 16'h0;
`ifdef WB_BYPASS_EN
        if (we && wa == r) return wd;
`endif
        return m_regs[r];
    endfunction

    task automatic model_eval(input logic [15:0] i_pc, input logic [15:0] i_inst, input bit iv,
                              input bit br, input bit we, input logic [3:0] wa,
                              input logic [15:0] wd);
        logic [15:0] ci, cp;
        logic [7:0]  lo;
        bit          take;
        take = 0; n_mode = m_mode; m_fs = 0; ci = i_inst; cp = i_pc;
        n_valid = 0; n_wben = 0; n_pc = exp_pc; n_op = exp_op; n_rd = exp_rd;
        n_a = exp_a; n_b = exp_b; n_imm = exp_imm;
        if (br) begin
            n_mode = ModeFlush;
        end else if (m_mode == ModeFlush) begin
            n_mode = ModeRun;
        end else if (m_mode == ModeRun) begin
            if (iv) begin
                if (uses_pending_load(i_inst) || wb_clash(i_inst, we, wa)) begin
                    n_mode = ModeStall;
                    held_inst = i_inst;
                    held_pc = i_pc;
                end else begin
                    take = 1;
                end
            end
        end else begin
            m_fs = 1; ci = held_inst; cp = held_pc;
            if (!wb_clash(held_inst, we, wa)) begin
                take = 1;
                n_mode = ModeRun;
            end
        end
        if (take) begin
            lo = ci[7:0];
            n_valid = 1;
            n_pc = cp;
            n_op = ci[15:12];
            n_rd = ci[11:8];
            n_a = read_reg(ci[7:4], we, wa, wd);
            n_b = read_reg(ci[3:0], we, wa, wd);
            if (n_op == 4'hB) n_imm = {lo, 8'h00};
            else n_imm = (lo >= 8'd128) ? 16'hFF00 + 16'(lo) : 16'(lo);
            n_wben = (n_op <= 4'hC);
        end
        if (we && wa != 0) m_regs[wa] = wd;
    endtask

    task automatic model_commit();
        m_mode = n_mode;
        exp_valid = n_valid; exp_wben = n_wben; exp_pc = n_pc; exp_op = n_op;
        exp_rd = n_rd; exp_a = n_a; exp_b = n_b; exp_imm = n_imm;
    endtask

    bit last_fs;

    // One clock cycle: drive, compare at mid-cycle, advance the model at the edge
    task automatic cyc(input bit r, input logic [15:0] p, input logic [15:0] i, input bit iv,
                       input bit br, input bit we, input logic [3:0] wa, input logic [15:0] wd);
        rst = r; pc = p; inst = i; inst_valid = iv; branch_to_new = br;
        wb_en = we; wb_addr = wa; wb_data = wd;
        if (r) model_reset();
        #3;
        if (!r) model_eval(p, i, iv, br, we, wa, wd);
        chk("fetch_stall", {15'h0, fetch_stall}, {15'h0, m_fs});
        chk("ex_valid", {15'h0, ex_valid}, {15'h0, exp_valid});
        chk("ex_wb_en", {15'h0, ex_wb_en}, {15'h0, exp_wben});
        if (exp_valid) begin
            chk("ex_pc", ex_pc, exp_pc);
            chk("ex_op", {12'h0, ex_op}, {12'h0, exp_op});
            chk("ex_rd", {12'h0, ex_rd}, {12'h0, exp_rd});
            chk("ex_a", ex_a, exp_a);
            chk("ex_b", ex_b, exp_b);
            chk("ex_imm", ex_imm, exp_imm);
        end
        last_fs = fetch_stall;
        @(posedge clk);
        #1;
        if (!r) model_commit();
    endtask

    logic [15:0] rp, ri;
    bit          riv;

    initial begin
        model_reset();
        rst = 1; pc = 0; inst = 0; inst_valid = 0; branch_to_new = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0;
        @(posedge clk);
        #1;
        cyc(1, 16'h0, 16'h0, 0, 0, 1, 4'd2, 16'hAAAA);
        cyc(1, 16'h0, 16'h0, 0, 0, 0, 4'd0, 16'h0);
        chk("rst_ex_valid", {15'h0, ex_valid}, 16'h0);
        chk("rst_ex_wb_en", {15'h0, ex_wb_en}, 16'h0);
        chk("rst_ex_pc", ex_pc, 16'h0);
        chk("rst_ex_a", ex_a, 16'h0);
        chk("rst_ex_imm", ex_imm, 16'h0);
        chk("rst_fetch_stall", {15'h0, fetch_stall}, 16'h0);

        // First instruction after reset is discarded by FLUSH
        cyc(0, 16'h0100, 16'h1123, 1, 0, 1, 4'd2, 16'h2222);
        chk("t34_flush_valid", {15'h0, ex_valid}, 16'h0);
        cyc(0, 16'h0101, 16'h0000, 0, 0, 1, 4'd3, 16'h3333);
        cyc(0, 16'h0102, 16'h1123, 1, 0, 0, 4'd0, 16'h0);
        chk("t34_valid", {15'h0, ex_valid}, 16'h1);
        chk("t34_op", {12'h0, ex_op}, 16'h1);
        chk("t34_rd", {12'h0, ex_rd}, 16'h1);
        chk("t34_a", ex_a, 16'h2222);
        chk("t34_b", ex_b, 16'h3333);

        // Load-use: one stall cycle, one bubble, then the held instruction
        cyc(0, 16'h0103, 16'h0000, 0, 0, 1, 4'd5, 16'h5555);
        cyc(0, 16'h0104, 16'hC500, 1, 0, 0, 4'd0, 16'h0);
        chk("t35_load_op", {12'h0, ex_op}, 16'h000C);
        chk("t35_load_wben", {15'h0, ex_wb_en}, 16'h1);
        cyc(0, 16'h0105, 16'h1653, 1, 0, 0, 4'd0, 16'h0);
        chk("t35_detect_fs", {15'h0, last_fs}, 16'h0);
        chk("t35_bubble", {15'h0, ex_valid}, 16'h0);
        cyc(0, 16'h0106, 16'h7000, 1, 0, 0, 4'd0, 16'h0);
        chk("t35_stall_fs", {15'h0, last_fs}, 16'h1);
        chk("t35_op", {12'h0, ex_op}, 16'h1);
        chk("t35_a", ex_a, 16'h5555);
        chk("t35_pc", ex_pc, 16'h0105);
        cyc(0, 16'h0106, 16'h7000, 1, 0, 0, 4'd0, 16'h0);
        chk("t35_after_fs", {15'h0, last_fs}, 16'h0);
        chk("t35_next_op", {12'h0, ex_op}, 16'h7);

        // Redirect during a pending stall: no fetch stall, two bubbles
        cyc(0, 16'h0107, 16'hC700, 1, 0, 0, 4'd0, 16'h0);
        cyc(0, 16'h0108, 16'h1270, 1, 0, 0, 4'd0, 16'h0);
        cyc(0, 16'h0109, 16'h2000, 1, 1, 0, 4'd0, 16'h0);
        chk("t36_fs", {15'h0, last_fs}, 16'h0);
        chk("t36_bubble1", {15'h0, ex_valid}, 16'h0);
        cyc(0, 16'h0200, 16'h3000, 1, 0, 0, 4'd0, 16'h0);
        chk("t36_bubble2", {15'h0, ex_valid}, 16'h0);
        cyc(0, 16'h0201, 16'h1120, 1, 0, 0, 4'd0, 16'h0);
        chk("t36_resume", {15'h0, ex_valid}, 16'h1);
        chk("t36_pc", ex_pc, 16'h0201);

        // Same-cycle writeback to a source register
        cyc(0, 16'h0202, 16'h2340, 1, 0, 1, 4'd4, 16'hBEEF);
`ifdef WB_BYPASS_EN
        chk("t37_a", ex_a, 16'hBEEF);
        chk("t37_fs", {15'h0, last_fs}, 16'h0);
        cyc(0, 16'h0203, 16'h0000, 1, 0, 0, 4'd0, 16'h0);
        chk("t37_nostall", {15'h0, last_fs}, 16'h0);
`else
        chk("t37_bubble", {15'h0, ex_valid}, 16'h0);
        cyc(0, 16'h0203, 16'h0000, 1, 0, 0, 4'd0, 16'h0);
        chk("t37_stall_fs", {15'h0, last_fs}, 16'h1);
        chk("t37_a", ex_a, 16'hBEEF);
        cyc(0, 16'h0203, 16'h0000, 1, 0, 0, 4'd0, 16'h0);
        chk("t37_one_stall", {15'h0, last_fs}, 16'h0);
`endif

        // Immediates and r0
        cyc(0, 16'h0204, 16'hB0FF, 1, 0, 0, 4'd0, 16'h0);
        chk("t38_lui_imm", ex_imm, 16'hFF00);
        chk("t38_lui_wben", {15'h0, ex_wb_en}, 16'h1);
        cyc(0, 16'h0205, 16'h3080, 1, 0, 0, 4'd0, 16'h0);
        chk("t38_sext_imm", ex_imm, 16'hFF80);
        cyc(0, 16'h0206, 16'h0000, 0, 0, 1, 4'd0, 16'h1234);
        cyc(0, 16'h0207, 16'hD100, 1, 0, 0, 4'd0, 16'h0);
        chk("t38_r0_a", ex_a, 16'h0000);
        chk("t38_store_wben", {15'h0, ex_wb_en}, 16'h0);

        // Randomized traffic; fetch holds its instruction while stalled
        rp = 16'h1000; ri = 16'h0; riv = 0;
        for (int k = 0; k < 4000; k++) begin
            bit r, br, we;
            logic [3:0] wa, op;
            if (!m_fs) begin
                rp = rp + 16'd1;
                op = ($urandom_range(0, 3) == 0) ? 4'hC : 4'($urandom_range(0, 15));
                ri = {op, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                      4'($urandom_range(0, 7))};
                if ($urandom_range(0, 3) == 0) ri[7:0] = 8'($urandom);
                riv = ($urandom_range(0, 9) != 0);
            end
            r  = ($urandom_range(0, 299) == 0);
            br = ($urandom_range(0, 15) == 0);
            we = ($urandom_range(0, 2) == 0);
            wa = 4'($urandom_range(0, 7));
            cyc(r, rp, ri, riv, br, we, wa, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
